// File: rtl/sparc_rf_pkg.sv
// Shared constants for the windowed register file: region bases, block geometry
// and the logical-to-physical index helper used by rf_addr_map.
package sparc_rf_pkg;

  localparam int MAX_NWIN    = 32;
  localparam int GLOBAL_BASE = 0;
  localparam int WIN_BASE    = 8;
  localparam int BLOCK_SIZE  = 16;
  localparam int OUT_OFF     = 0;
  localparam int LOCAL_OFF   = 8;
  localparam int IN_OFF      = 0;

  typedef enum logic [1:0] {
    REG_GLOBAL = 2'd0,
    REG_OUT    = 2'd1,
    REG_LOCAL  = 2'd2,
    REG_IN     = 2'd3
  } region_e;

  function automatic region_e region_of(logic [4:0] addr);
    return region_e'(addr[4:3]);
  endfunction

  // The ins of window w alias the outs of window w+1, which is what lets SAVE
  // hand arguments to the callee without copying.
  function automatic int phys_index(logic [4:0] addr, int cwp, int nwin);
    int ofs;
    ofs = int'(addr[2:0]);
    case (region_of(addr))
      REG_GLOBAL: return GLOBAL_BASE + ofs;
      REG_OUT:    return WIN_BASE + cwp * BLOCK_SIZE + OUT_OFF + ofs;
      REG_LOCAL:  return WIN_BASE + cwp * BLOCK_SIZE + LOCAL_OFF + ofs;
      default:    return WIN_BASE + ((cwp + 1) % nwin) * BLOCK_SIZE + IN_OFF + ofs;
    endcase
  endfunction

endpackage

// File: rtl/windowed_regfile_if.sv
// Register-file access and window-control bundle between a core and windowed_regfile.
interface windowed_regfile_if #(
    parameter int NWIN = 4,
    parameter int W    = 32
);
    // No handshake: every request is sampled on each rising clock edge and is
    // always accepted; result pulses come back exactly one cycle later.
    logic [4:0]      RA;
    logic [4:0]      RB;
    logic [4:0]      RC;
    logic [W-1:0]    Rin;
    logic            RFE;
    logic [W-1:0]    Aout;
    logic [W-1:0]    Bout;
    logic            SAVE;
    logic            RESTORE;
    logic            CWP_LD;
    logic [4:0]      CWP_IN;
    logic            WIME;
    logic [NWIN-1:0] WIM_IN;
    logic [4:0]      CWP;
    logic [NWIN-1:0] WIM;
    logic            WOVF;
    logic            WUNF;
    logic            WERR;

    modport master (
        output RA, RB, RC, Rin, RFE, SAVE, RESTORE, CWP_LD, CWP_IN, WIME, WIM_IN,
        input  Aout, Bout, CWP, WIM, WOVF, WUNF, WERR
    );

    modport slave (
        input  RA, RB, RC, Rin, RFE, SAVE, RESTORE, CWP_LD, CWP_IN, WIME, WIM_IN,
        output Aout, Bout, CWP, WIM, WOVF, WUNF, WERR
    );
endinterface

// File: rtl/rf_addr_map.sv
// Combinational map from a logical register number in window cwp_i to a
// physical storage index.
module rf_addr_map
    import sparc_rf_pkg::*;
#(
    parameter int NWIN = 4,
    parameter int CW   = 2,
    parameter int PW   = 7
) (
    input  logic [4:0]    addr_i,
    input  logic [CW-1:0] cwp_i,
    output logic [PW-1:0] idx_o
);
    assign idx_o = PW'(phys_index(addr_i, int'(cwp_i), NWIN));
endmodule

// File: rtl/windowed_regfile.sv
// SPARC-style windowed register file: 8 globals plus 16 registers per window,
// with CWP/WIM window control and overflow/underflow/conflict pulses.
module windowed_regfile
    import sparc_rf_pkg::*;
#(
    parameter int NWIN = 4,
    parameter int W    = 32
) (
    input logic               Clk,
    input logic               Reset,
    windowed_regfile_if.slave bus
);
    localparam int CW    = $clog2(NWIN);
    localparam int NPHYS = WIN_BASE + BLOCK_SIZE * NWIN;
    localparam int PW    = $clog2(NPHYS);

    logic [W-1:0]    regs_q [NPHYS];
    logic [CW-1:0]   cwp_q, cwp_d;
    logic [NWIN-1:0] wim_q, wim_d;
    logic            wovf_q, wovf_d;
    logic            wunf_q, wunf_d;
    logic            werr_q, werr_d;
    logic [CW-1:0]   cwp_up, cwp_dn;
    logic [PW-1:0]   aidx, bidx, widx;

    rf_addr_map #(.NWIN(NWIN), .CW(CW), .PW(PW)) u_map_a (.addr_i(bus.RA), .cwp_i(cwp_q), .idx_o(aidx));
    rf_addr_map #(.NWIN(NWIN), .CW(CW), .PW(PW)) u_map_b (.addr_i(bus.RB), .cwp_i(cwp_q), .idx_o(bidx));
    rf_addr_map #(.NWIN(NWIN), .CW(CW), .PW(PW)) u_map_c (.addr_i(bus.RC), .cwp_i(cwp_q), .idx_o(widx));

    // Explicit wrap compare keeps non-power-of-two window counts correct.
    assign cwp_up = (cwp_q == CW'(NWIN - 1)) ? '0 : cwp_q + CW'(1);
    assign cwp_dn = (cwp_q == '0) ? CW'(NWIN - 1) : cwp_q - CW'(1);

    always_comb begin
        cwp_d  = cwp_q;
        wovf_d = 1'b0;
        wunf_d = 1'b0;
        werr_d = 1'b0;
        wim_d  = bus.WIME ? bus.WIM_IN : wim_q;
        if (bus.CWP_LD) begin
            cwp_d = CW'(int'(bus.CWP_IN) % NWIN);
        end else if (bus.SAVE && bus.RESTORE) begin
            werr_d = 1'b1;
        end else if (bus.SAVE) begin
            if (wim_q[cwp_dn]) wovf_d = 1'b1;
            else               cwp_d  = cwp_dn;
        end else if (bus.RESTORE) begin
            if (wim_q[cwp_up]) wunf_d = 1'b1;
            else               cwp_d  = cwp_up;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cwp_q  <= '0;
            wim_q  <= '0;
            wovf_q <= 1'b0;
            wunf_q <= 1'b0;
            werr_q <= 1'b0;
        end else begin
            cwp_q  <= cwp_d;
            wim_q  <= wim_d;
            wovf_q <= wovf_d;
            wunf_q <= wunf_d;
            werr_q <= werr_d;
        end
    end

    // Storage is deliberately not cleared; r0 is forced to zero on the read side.
    always_ff @(posedge Clk) begin
        if (!Reset && bus.RFE && (bus.RC != 5'd0)) begin
            regs_q[widx] <= bus.Rin;
        end
    end

    assign bus.Aout = (bus.RA == 5'd0) ? '0 : regs_q[aidx];
    assign bus.Bout = (bus.RB == 5'd0) ? '0 : regs_q[bidx];
    assign bus.CWP  = 5'(cwp_q);
    assign bus.WIM  = wim_q;
    assign bus.WOVF = wovf_q;
    assign bus.WUNF = wunf_q;
    assign bus.WERR = werr_q;
endmodule

// File: tb/tb_windowed_regfile.sv
// Directed bench for windowed_regfile: a 4-window/32-bit instance for the
// window mapping and CWP/WIM control, and an 8-window/16-bit instance for reset.
module tb_windowed_regfile;
  import sparc_rf_pkg::*;

  logic clk;
  logic rst4;
  logic rst8;
  int   n_checks;
  int   n_errors;

  windowed_regfile_if #(.NWIN(4), .W(32)) bus4 ();
  windowed_regfile_if #(.NWIN(8), .W(16)) bus8 ();

  windowed_regfile #(.NWIN(4), .W(32)) dut4 (.Clk(clk), .Reset(rst4), .bus(bus4));
  windowed_regfile #(.NWIN(8), .W(16)) dut8 (.Clk(clk), .Reset(rst8), .bus(bus8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    bus4.RA = '0; bus4.RB = '0; bus4.RC = '0; bus4.Rin = '0; bus4.RFE = 1'b0;
    bus4.SAVE = 1'b0; bus4.RESTORE = 1'b0; bus4.CWP_LD = 1'b0; bus4.CWP_IN = '0;
    bus4.WIME = 1'b0; bus4.WIM_IN = '0;
  endtask

  task automatic idle8();
    bus8.RA = '0; bus8.RB = '0; bus8.RC = '0; bus8.Rin = '0; bus8.RFE = 1'b0;
    bus8.SAVE = 1'b0; bus8.RESTORE = 1'b0; bus8.CWP_LD = 1'b0; bus8.CWP_IN = '0;
    bus8.WIME = 1'b0; bus8.WIM_IN = '0;
  endtask

  task automatic write4(input logic [4:0] rc, input logic [31:0] d);
    bus4.RC = rc; bus4.Rin = d; bus4.RFE = 1'b1;
    tick();
    bus4.RFE = 1'b0;
  endtask

  task automatic pulses4(input string tag, input logic [2:0] exp);
    check(tag, {bus4.WOVF, bus4.WUNF, bus4.WERR}, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle4();
    idle8();
    rst4 = 1'b1;
    rst8 = 1'b1;
    tick();
    tick();
    rst4 = 1'b0;
    #1;
    check("rst_cwp", bus4.CWP, 5'd0);
    check("rst_wim", bus4.WIM, 4'h0);
    pulses4("rst_pulses", 3'b000);
    check("rst_r0", bus4.Aout, 32'h0);

    // outs of window 0 become the ins of window 3 after SAVE
    write4(5'd8, 32'hAAAA_0001);
    bus4.SAVE = 1'b1;
    tick();
    bus4.SAVE = 1'b0;
    check("save_cwp", bus4.CWP, 5'd3);
    pulses4("save_pulses", 3'b000);
    bus4.RA = 5'd24;
    #1;
    check("save_r24", bus4.Aout, 32'hAAAA_0001);

    // globals are shared; CWP_LD takes CWP_IN mod NWIN and ignores SAVE
    bus4.CWP_LD = 1'b1; bus4.CWP_IN = 5'd0;
    tick();
    idle4();
    write4(5'd3, 32'h1234_5678);
    bus4.CWP_LD = 1'b1; bus4.CWP_IN = 5'd6; bus4.SAVE = 1'b1;
    tick();
    idle4();
    check("ld_cwp_mod", bus4.CWP, 5'd2);
    pulses4("ld_pulses", 3'b000);
    bus4.RA = 5'd3;
    #1;
    check("global_r3", bus4.Aout, 32'h1234_5678);
    write4(5'd0, 32'hFFFF_FFFF);
    bus4.RA = 5'd0; bus4.RB = 5'd0;
    #1;
    check("r0_a", bus4.Aout, 32'h0);
    check("r0_b", bus4.Bout, 32'h0);

    // overflow: WIM=1000 at CWP=0 blocks SAVE into window 3
    bus4.WIME = 1'b1; bus4.WIM_IN = 4'b1000; bus4.CWP_LD = 1'b1; bus4.CWP_IN = 5'd0;
    tick();
    idle4();
    check("wim_load", bus4.WIM, 4'b1000);
    bus4.SAVE = 1'b1;
    tick();
    bus4.SAVE = 1'b0;
    pulses4("wovf_pulse", 3'b100);
    check("wovf_cwp", bus4.CWP, 5'd0);
    tick();
    pulses4("wovf_gone", 3'b000);
    bus4.RESTORE = 1'b1;
    tick();
    bus4.RESTORE = 1'b0;
    check("restore_cwp", bus4.CWP, 5'd1);
    pulses4("restore_pulses", 3'b000);

    // SAVE sees the old WIM (bit0 clear) even though WIME sets bit0 this edge
    bus4.SAVE = 1'b1; bus4.WIME = 1'b1; bus4.WIM_IN = 4'b0001;
    tick();
    idle4();
    check("oldwim_cwp", bus4.CWP, 5'd0);
    pulses4("oldwim_pulses", 3'b000);
    check("oldwim_wim", bus4.WIM, 4'b0001);

    // underflow and conflicting requests at CWP=3
    bus4.CWP_LD = 1'b1; bus4.CWP_IN = 5'd3;
    tick();
    idle4();
    bus4.RESTORE = 1'b1;
    tick();
    bus4.RESTORE = 1'b0;
    pulses4("wunf_pulse", 3'b010);
    check("wunf_cwp", bus4.CWP, 5'd3);
    bus4.SAVE = 1'b1; bus4.RESTORE = 1'b1;
    tick();
    idle4();
    pulses4("werr_pulse", 3'b001);
    check("werr_cwp", bus4.CWP, 5'd3);
    tick();
    pulses4("werr_gone", 3'b000);

    // RESTORE wraps from NWIN-1 to 0 once WIM is clear
    bus4.WIME = 1'b1; bus4.WIM_IN = 4'b0000;
    tick();
    idle4();
    bus4.RESTORE = 1'b1;
    tick();
    bus4.RESTORE = 1'b0;
    check("wrap_cwp", bus4.CWP, 5'd0);
    pulses4("wrap_pulses", 3'b000);

    // no write-to-read bypass
    write4(5'd16, 32'h0000_0011);
    bus4.RC = 5'd16; bus4.Rin = 32'h5; bus4.RFE = 1'b1; bus4.RA = 5'd16; bus4.RB = 5'd16;
    #1;
    check("nobypass_a", bus4.Aout, 32'h11);
    tick();
    bus4.RFE = 1'b0;
    #1;
    check("after_a", bus4.Aout, 32'h5);
    check("after_b", bus4.Bout, 32'h5);

    // 8-window, 16-bit instance: first request accepted on the first free edge
    rst8 = 1'b0;
    bus8.RESTORE = 1'b1;
    tick();
    bus8.RESTORE = 1'b0;
    check("n8_first_cwp", bus8.CWP, 5'd1);
    bus8.RC = 5'd9; bus8.Rin = 16'hBEEF; bus8.RFE = 1'b1;
    tick();
    bus8.RFE = 1'b0;
    bus8.RA = 5'd9;
    #1;
    check("n8_r9", bus8.Aout, 16'hBEEF);
    bus8.CWP_LD = 1'b1; bus8.CWP_IN = 5'd7; bus8.WIME = 1'b1; bus8.WIM_IN = 8'h40;
    tick();
    idle8();
    check("n8_cwp7", bus8.CWP, 5'd7);
    check("n8_wim", bus8.WIM, 8'h40);

    // SAVE would overflow into window 6, but Reset wins
    bus8.SAVE = 1'b1; bus8.RFE = 1'b1; bus8.RC = 5'd0; bus8.Rin = 16'hFFFF;
    rst8 = 1'b1;
    tick();
    idle8();
    check("n8_rst_cwp", bus8.CWP, 5'd0);
    check("n8_rst_wim", bus8.WIM, 8'h00);
    check("n8_rst_pulses", {bus8.WOVF, bus8.WUNF, bus8.WERR}, 3'b000);
    rst8 = 1'b0;
    tick();
    check("n8_post_pulses", {bus8.WOVF, bus8.WUNF, bus8.WERR}, 3'b000);
    check("n8_post_cwp", bus8.CWP, 5'd0);
    check("n8_r0", bus8.Aout, 16'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/windowed_regfile.md
WINDOWED_REGFILE -- requirements
Module: windowed_regfile

Interface
REQ-001 Parameter NWIN, default 4, number of register windows (legal range 2..32).
REQ-002 Parameter W, default 32, data width in bits.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 RA, RB  in  5 each  logical read addresses, r0..r31 of the current window.
REQ-006 RC  in  5  logical write address.
REQ-007 Rin  in  W  write data.
REQ-008 RFE  in  1  write enable.
REQ-009 Aout, Bout  out  W each  read data for RA, RB.
REQ-010 SAVE, RESTORE  in  1 each  window-shift requests.
REQ-011 CWP_LD  in  1  load CWP from CWP_IN; CWP_IN  in  5.
REQ-012 WIME  in  1  load WIM from WIM_IN; WIM_IN  in  NWIN.
REQ-013 CWP  out  5  current window pointer; WIM  out  NWIN  window invalid mask.
REQ-014 WOVF, WUNF, WERR  out  1 each  one-cycle pulses: window overflow, window underflow, conflicting request.

Function
REQ-015 Physical storage SHALL be 8 global + 16*NWIN windowed registers of W bits.
REQ-016 r0 SHALL read as 0; writes to r0 SHALL be discarded.
REQ-017 r1..r7 SHALL map to globals, shared by all windows.
REQ-018 For window w: outs r8..r15 -> block w, offset 0..7; locals r16..r23 -> block w, offset 8..15; ins r24..r31 -> block (w+1) mod NWIN, offset 0..7.
REQ-019 Reads SHALL be combinational from current CWP; a same-cycle write to the read address SHALL NOT bypass (old value until the edge).
REQ-020 A write SHALL occur at the rising edge when RFE=1 and RC!=0, using the CWP value before that edge.
REQ-021 CWP update priority SHALL be: Reset > CWP_LD > SAVE/RESTORE.
REQ-022 CWP_LD: CWP <- CWP_IN mod NWIN; concurrent SAVE/RESTORE ignored, no pulses.
REQ-023 SAVE alone: if WIM[(CWP-1) mod NWIN]=1, assert WOVF next cycle and hold CWP; else CWP <- (CWP-1) mod NWIN.
REQ-024 RESTORE alone: if WIM[(CWP+1) mod NWIN]=1, assert WUNF next cycle and hold CWP; else CWP <- (CWP+1) mod NWIN.
REQ-025 SAVE and RESTORE together: CWP held, WERR asserted next cycle.
REQ-026 WIM check SHALL use the WIM value before the edge; WIME and SAVE in the same cycle use old WIM.
REQ-027 Wrap-around: SAVE at CWP=0 targets NWIN-1; RESTORE at CWP=NWIN-1 targets 0.
REQ-028 WOVF, WUNF, WERR SHALL each be high exactly one cycle per triggering request, low otherwise.
REQ-029 CWP upper bits beyond log2(NWIN) SHALL read 0.

Reset
REQ-030 On Reset: CWP=0, WIM=0, WOVF=WUNF=WERR=0; register contents undefined except r0.
REQ-031 Reset SHALL override a concurrent RFE write, CWP_LD, WIME, SAVE, RESTORE.
REQ-032 First request accepted on the first edge with Reset=0.

Structure
REQ-033 Shared package sparc_rf_pkg SHALL hold region base constants (GLOBAL, OUT, LOCAL, IN offsets) and max window count 32.
REQ-034 One sub-module, rf_addr_map: combinational logical-to-physical index from (addr, cwp, NWIN), instantiated three times (RA, RB, RC).

Verification
REQ-035 NWIN=4: CWP=0, write r8=0xAAAA0001; SAVE -> CWP=3; read r24 -> 0xAAAA0001.
REQ-036 NWIN=4: write r3=0x12345678 in CWP=0; CWP_LD to 2; read r3 -> 0x12345678; write r0=0xFFFFFFFF, read r0 -> 0.
REQ-037 WIM=0b1000, CWP=0, SAVE -> WOVF=1 one cycle, CWP stays 0; RESTORE -> CWP=1, no pulse.
REQ-038 CWP=3, WIM=0b0001, RESTORE -> WUNF=1, CWP=3; SAVE+RESTORE together -> WERR=1, CWP=3.
REQ-039 Write r16=0x5 with RA=16 same cycle -> Aout old value that cycle, 0x5 next cycle.
REQ-040 NWIN=8, W=16: Reset asserted mid-SAVE -> CWP=0, WIM=0, no pulses following.
